// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for seq_magnitude_comparator.
// Optional SEQ_CMP_CYCLE_COUNT_EN adds the cycles result field.
interface seq_magnitude_comparator_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    logic             start;
    logic             mode;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             L;
    logic             E;
    logic             G;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
    logic [CW-1:0]    cycles;

    modport master (output start, mode, sgn, a, b,
                    input  busy, done, L, E, G, cycles);
    modport slave  (input  start, mode, sgn, a, b,
                    output busy, done, L, E, G, cycles);
`else
    modport master (output start, mode, sgn, a, b,
                    input  busy, done, L, E, G);
    modport slave  (input  start, mode, sgn, a, b,
                    output busy, done, L, E, G);
`endif
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: parallel or MSB-first serial with early exit.
// Optional SEQ_CMP_CYCLE_COUNT_EN reports the RUN cycles of the last compare.
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    seq_magnitude_comparator_if.slave    bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CW   = $clog2(NDIG + 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             l_q, l_d, e_q, e_d, g_q, g_d;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
    logic [CW-1:0]    cycles_q, cycles_d;
`endif

    logic [DIGIT-1:0] a_top, b_top;

    // Operands shift left each serial cycle, so the current digit is always on top.
    assign a_top = a_q[WIDTH-1 -: DIGIT];
    assign b_top = b_q[WIDTH-1 -: DIGIT];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
        cycles_d = cycles_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Flipping the MSB maps two's-complement order onto unsigned order.
                    a_d     = bus.a ^ (bus.sgn ? SIGN_MASK : '0);
                    b_d     = bus.b ^ (bus.sgn ? SIGN_MASK : '0);
                    mode_d  = bus.mode;
                    k_d     = KW'(NDIG - 1);
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                    g_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!mode_q) begin
                    l_d    = a_q < b_q;
                    e_d    = a_q == b_q;
                    g_d    = a_q > b_q;
                    done_d = 1'b1;
                end else if (a_top != b_top) begin
                    l_d    = a_top < b_top;
                    g_d    = a_top > b_top;
                    done_d = 1'b1;
                end else if (k_q == '0) begin
                    e_d    = 1'b1;
                    done_d = 1'b1;
                end else begin
                    k_d = k_q - KW'(1);
                    a_d = a_q << DIGIT;
                    b_d = b_q << DIGIT;
                end
                if (done_d) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
                    cycles_d = CW'(NDIG) - CW'(k_q);
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
            cycles_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
            cycles_q <= cycles_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.L    = l_q;
    assign bus.E    = e_q;
    assign bus.G    = g_q;
`ifdef SEQ_CMP_CYCLE_COUNT_EN
    assign bus.cycles = cycles_q;
`endif
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised multi-cycle magnitude comparator. Compares two WIDTH-bit operands and reports less-than, equal and greater-than flags.
- Two compute modes:
  - parallel: single-cycle compare.
  - serial: MSB-first, DIGIT bits per cycle, with early termination at the first differing digit.
- Adds a signed compare option and a start/busy/done handshake.
- Used by datapath blocks that need comparisons with a bounded area/latency trade-off.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥2.
- DIGIT, 1, bits examined per serial cycle; must divide WIDTH exactly.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request pulse; samples a, b, mode and sgn.
- mode  in  1  0 = parallel compare, 1 = serial compare.
- sgn  in  1  0 = unsigned operands, 1 = two's-complement operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when L/E/G become valid.
- L  out  1  A < B.
- E  out  1  A == B.
- G  out  1  A > B.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - busy=0, done=0, L=0, E=0, G=0.
  - Internal operand registers and digit index are cleared.
  - Reset during RUN aborts the compare; no done pulse is issued.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start=1, latch a, b, mode and sgn into internal registers and go to RUN.
  - Clear L/E/G on the same edge.
- RUN, parallel mode (mode=1'b0):
  - Full-width compare in one cycle, then go to DONE.
  - Total latency: done asserts 2 cycles after the start edge.
- RUN, serial mode (mode=1'b1):
  - Digit index k starts at WIDTH/DIGIT-1 (most significant digit) and decrements by one per cycle.
  - Each cycle compares digit k of A against digit k of B.
  - If the digits differ, set L or G and go to DONE immediately (early termination).
  - If k=0 and the digits are equal, set E and go to DONE.
  - Worst-case RUN duration is WIDTH/DIGIT cycles.
- Signed compare (sgn=1):
  - In both modes, the operand MSB is inverted before comparison.
  - In serial mode this applies to the top digit only.
  - Result is correct two's-complement ordering.
- DONE:
  - done=1 for exactly one cycle; busy=0; return to IDLE.
  - busy is high for the whole of RUN.
- Outputs:
  - L/E/G are registered. Exactly one is high after the first completion.
  - They hold their value until the next accepted start or reset.
- Handshake:
  - start is ignored while busy=1 or in DONE.
  - Changes on a/b after the start edge do not affect the result.
  - Back-to-back operation: start may be asserted in the cycle done=1; it is accepted on the following IDLE edge.
- Boundaries:
  - a == b with all ones, and a == b with all zeros, yield E after the full digit count.
  - A difference confined to the LSB digit takes the maximum latency.

Optional Feature:
- Macro: SEQ_CMP_CYCLE_COUNT_EN.
- When defined:
  - Adds output port cycles [$clog2(WIDTH/DIGIT+1)-1:0].
  - It holds the number of RUN cycles used by the last completed compare (1 in parallel mode).
  - Updated with done; reset to 0.
- When undefined: the port and its counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-compare. WIDTH=32, DIGIT=1, serial, a=32'h00000001, b=32'h00000000. Drive rst=0 on the 5th RUN cycle, then release → busy=0 and L/E/G=0 immediately, no done pulse. A new compare of the same operands → G=1 after 32 RUN cycles.
- Serial early termination. a=32'h92929292, b=32'h92909292, unsigned → G=1. done arrives after RUN cycles equal to the number of digits down to and including the first differing bit (bit 17), i.e. 15 cycles with DIGIT=1. cycles=15 when SEQ_CMP_CYCLE_COUNT_EN is defined.
- Parallel compare. a=5, b=9, mode=0 → L=1, done 2 cycles after the start edge. With a=b=32'hFFFFFFFF → E=1.
- Signed compare. a=32'hFFFFFFFF (−1), b=32'h00000001, sgn=1 → L=1 in both modes. Same operands with sgn=0 → G=1.
- DIGIT=4, serial, a=b=32'h12345678 → E=1 after exactly 8 RUN cycles. A start pulse asserted during busy is ignored: no second done, and the result is unchanged.
- Back-to-back. Start asserted in the done cycle with new a=3, b=3 → second compare accepted and E=1. The previous flags are cleared at acceptance.
